// File: rtl/rename_dispatch_nw_pkg.sv
// Shared types for the rename/dispatch stage: opcodes, mul/div funct3,
// reservation-station classes, the per-lane decode bundle and a classifier.
package rename_dispatch_nw_pkg;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_IMM    = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    typedef enum logic [2:0] {
        F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU,
        F3_DIV, F3_DIVU, F3_REM, F3_REMU
    } muldiv_f3_e;

    typedef enum logic [1:0] {
        RS_ALU = 2'd0,
        RS_MUL = 2'd1,
        RS_DIV = 2'd2
    } rs_class_e;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef struct packed {
        opcode_e     opcode;
        logic [6:0]  funct7;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } decode_info_t;

    function automatic rs_class_e classify(
        input opcode_e    op,
        input logic [6:0] f7,
        input logic [2:0] f3
    );
        if (op == OPC_OP && f7 == F7_MULDIV)
            return (f3 >= F3_DIV) ? RS_DIV : RS_MUL;
        return RS_ALU;
    endfunction

endpackage

// File: rtl/rename_dispatch_nw_decode.sv
// Per-lane combinational decode for dispatch.
// Ports: i_inst (32b instruction) -> o_info (decode fields with unused
// register fields zeroed), o_cls (RS class), o_needs_preg (rd != x0).
module rename_dispatch_nw_decode
    import rename_dispatch_nw_pkg::*;
(
    input  logic [31:0]  i_inst,
    output decode_info_t o_info,
    output rs_class_e    o_cls,
    output logic         o_needs_preg
);

    opcode_e w_op;
    logic    w_has_rd;
    logic    w_has_rs1;
    logic    w_has_rs2;

    always_comb begin
        w_op      = opcode_e'(i_inst[6:0]);
        w_has_rd  = 1'b1;
        w_has_rs1 = 1'b1;
        w_has_rs2 = 1'b0;
        // Field positions that hold immediate bits are not register reads/writes.
        unique case (1'b1)
            (w_op == OPC_LUI) || (w_op == OPC_AUIPC) || (w_op == OPC_JAL):
                w_has_rs1 = 1'b0;
            (w_op == OPC_BRANCH) || (w_op == OPC_STORE): begin
                w_has_rd  = 1'b0;
                w_has_rs2 = 1'b1;
            end
            (w_op == OPC_OP):
                w_has_rs2 = 1'b1;
            default: ;
        endcase

        o_info.opcode = w_op;
        o_info.funct7 = i_inst[31:25];
        o_info.funct3 = i_inst[14:12];
        o_info.rd     = w_has_rd  ? i_inst[11:7]  : 5'd0;
        o_info.rs1    = w_has_rs1 ? i_inst[19:15] : 5'd0;
        o_info.rs2    = w_has_rs2 ? i_inst[24:20] : 5'd0;
        o_cls         = classify(w_op, i_inst[31:25], i_inst[14:12]);
        o_needs_preg  = (o_info.rd != 5'd0);
    end

endmodule

// File: rtl/rename_dispatch_nw.sv
// N-wide in-order rename/dispatch: renames the longest resource-fitting
// prefix of the IQ head, bypasses intra-group RAW, registers the packet.
// Ports: iq_* (IQ head/pop), fl_* (free list), rob_* / rs_free (capacity),
// rat_* (RAT read/write), out_* (registered dispatch packet).
// Optional RENAME_DISPATCH_RVFI_EN adds out_order, out_pc_wdata,
// out_rs1_s, out_rs2_s, out_regf_we and the 64b retire-order counter.
module rename_dispatch_nw
    import rename_dispatch_nw_pkg::*;
#(
    parameter int WIDTH         = 2,
    parameter int PHYS_REG_BITS = 6,
    parameter int ROB_IDX_BITS  = 5,
    parameter int NUM_RS        = 3,
    parameter int CNT_BITS      = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [WIDTH-1:0]               iq_valid,
    input  logic [WIDTH*32-1:0]            iq_inst,
    input  logic [WIDTH*32-1:0]            iq_pc,
    output logic [CNT_BITS-1:0]            iq_deq_cnt,
    input  logic [CNT_BITS-1:0]            fl_avail,
    input  logic [WIDTH*PHYS_REG_BITS-1:0] fl_preg,
    output logic [CNT_BITS-1:0]            fl_deq_cnt,
    input  logic [CNT_BITS-1:0]            rob_free,
    input  logic [ROB_IDX_BITS-1:0]        rob_tail,
    input  logic [NUM_RS*CNT_BITS-1:0]     rs_free,
    output logic [WIDTH*5-1:0]             rat_rs1,
    output logic [WIDTH*5-1:0]             rat_rs2,
    input  logic [WIDTH*PHYS_REG_BITS-1:0] rat_ps1,
    input  logic [WIDTH*PHYS_REG_BITS-1:0] rat_ps2,
    input  logic [WIDTH-1:0]               rat_v1,
    input  logic [WIDTH-1:0]               rat_v2,
    output logic [WIDTH-1:0]               rat_we,
    output logic [WIDTH*5-1:0]             rat_rd,
    output logic [WIDTH*PHYS_REG_BITS-1:0] rat_pd,
    output logic [WIDTH-1:0]               out_valid,
    output decode_info_t [WIDTH-1:0]       out_info,
    output logic [WIDTH*PHYS_REG_BITS-1:0] out_pd,
    output logic [WIDTH*PHYS_REG_BITS-1:0] out_ps1,
    output logic [WIDTH*PHYS_REG_BITS-1:0] out_ps2,
    output logic [WIDTH-1:0]               out_v1,
    output logic [WIDTH-1:0]               out_v2,
    output logic [WIDTH*ROB_IDX_BITS-1:0]  out_rob_idx,
`ifdef RENAME_DISPATCH_RVFI_EN
    output logic [WIDTH*64-1:0]            out_order,
    output logic [WIDTH*32-1:0]            out_pc_wdata,
    output logic [WIDTH*5-1:0]             out_rs1_s,
    output logic [WIDTH*5-1:0]             out_rs2_s,
    output logic [WIDTH-1:0]               out_regf_we,
`endif
    output logic [WIDTH*2-1:0]             out_rs_class
);

    localparam int PRB = PHYS_REG_BITS;
    localparam int RIB = ROB_IDX_BITS;

    decode_info_t         w_info [WIDTH];
    rs_class_e            w_cls  [WIDTH];
    logic [WIDTH-1:0]     w_need;
    logic [PRB-1:0]       w_fl   [WIDTH];
    logic [PRB-1:0]       w_rps1 [WIDTH];
    logic [PRB-1:0]       w_rps2 [WIDTH];
    logic [CNT_BITS-1:0]  w_rsf  [NUM_RS];

    logic [PRB-1:0]       w_pd   [WIDTH];
    logic [PRB-1:0]       w_ps1  [WIDTH];
    logic [PRB-1:0]       w_ps2  [WIDTH];
    logic [WIDTH-1:0]     w_v1;
    logic [WIDTH-1:0]     w_v2;
    logic [WIDTH-1:0]     w_disp;
    logic [CNT_BITS-1:0]  w_cfl;
    logic [CNT_BITS-1:0]  w_crs  [NUM_RS];
    logic [CNT_BITS-1:0]  w_deq;
    logic [CNT_BITS-1:0]  w_fldeq;
    logic                 w_prev;
    logic                 w_rsok;

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_lane
            rename_dispatch_nw_decode u_dec (
                .i_inst       (iq_inst[g*32 +: 32]),
                .o_info       (w_info[g]),
                .o_cls        (w_cls[g]),
                .o_needs_preg (w_need[g])
            );
            assign w_fl[g]   = fl_preg[g*PRB +: PRB];
            assign w_rps1[g] = rat_ps1[g*PRB +: PRB];
            assign w_rps2[g] = rat_ps2[g*PRB +: PRB];

            assign rat_we[g]           = w_disp[g] & w_need[g];
            assign rat_rs1[g*5 +: 5]   = rst ? 5'd0 : w_info[g].rs1;
            assign rat_rs2[g*5 +: 5]   = rst ? 5'd0 : w_info[g].rs2;
            assign rat_rd[g*5 +: 5]    = rst ? 5'd0 : w_info[g].rd;
            assign rat_pd[g*PRB +: PRB] = rst ? '0 : w_pd[g];
        end
        for (g = 0; g < NUM_RS; g++) begin : g_rs
            assign w_rsf[g] = rs_free[g*CNT_BITS +: CNT_BITS];
        end
    endgenerate

    always_comb begin
        w_cfl   = '0;
        w_deq   = '0;
        w_fldeq = '0;
        w_disp  = '0;
        w_v1    = '0;
        w_v2    = '0;
        w_rsok  = 1'b0;
        // Any lane failing breaks the chain for all younger lanes.
        w_prev  = !rst && !flush;
        for (int c = 0; c < NUM_RS; c++)
            w_crs[c] = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pd[i]  = '0;
            w_ps1[i] = '0;
            w_ps2[i] = '0;
        end

        for (int i = 0; i < WIDTH; i++) begin
            // Free-list head entries go, in order, only to lanes writing rd.
            if (w_need[i])
                for (int k = 0; k < WIDTH; k++)
                    if (k == int'(w_cfl))
                        w_pd[i] = w_fl[k];
            w_cfl = w_cfl + CNT_BITS'(w_need[i]);

            w_rsok = 1'b0;
            for (int c = 0; c < NUM_RS; c++)
                if (int'(w_cls[i]) == c) begin
                    w_crs[c] = w_crs[c] + CNT_BITS'(1);
                    w_rsok   = (w_crs[c] <= w_rsf[c]);
                end

            w_disp[i] = w_prev && iq_valid[i] && w_rsok
                     && (w_cfl <= fl_avail)
                     && (CNT_BITS'(i + 1) <= rob_free);
            w_prev  = w_disp[i];
            w_deq   = w_deq + CNT_BITS'(w_disp[i]);
            w_fldeq = w_fldeq + CNT_BITS'(w_disp[i] & w_need[i]);

            // Ascending scan leaves the youngest older producer in place.
            w_ps1[i] = w_rps1[i];
            w_v1[i]  = rat_v1[i];
            w_ps2[i] = w_rps2[i];
            w_v2[i]  = rat_v2[i];
            for (int j = 0; j < i; j++) begin
                if (w_info[j].rd == w_info[i].rs1) begin
                    w_ps1[i] = w_pd[j];
                    w_v1[i]  = 1'b0;
                end
                if (w_info[j].rd == w_info[i].rs2) begin
                    w_ps2[i] = w_pd[j];
                    w_v2[i]  = 1'b0;
                end
            end
            if (w_info[i].rs1 == 5'd0) begin
                w_ps1[i] = '0;
                w_v1[i]  = 1'b1;
            end
            if (w_info[i].rs2 == 5'd0) begin
                w_ps2[i] = '0;
                w_v2[i]  = 1'b1;
            end
        end
    end

    assign iq_deq_cnt = w_deq;
    assign fl_deq_cnt = w_fldeq;

    logic [WIDTH-1:0]             r_valid;
    decode_info_t [WIDTH-1:0]     r_info;
    logic [WIDTH*PRB-1:0]         r_pd;
    logic [WIDTH*PRB-1:0]         r_ps1;
    logic [WIDTH*PRB-1:0]         r_ps2;
    logic [WIDTH-1:0]             r_v1;
    logic [WIDTH-1:0]             r_v2;
    logic [WIDTH*RIB-1:0]         r_rob;
    logic [WIDTH*2-1:0]           r_cls;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_info  <= '0;
            r_pd    <= '0;
            r_ps1   <= '0;
            r_ps2   <= '0;
            r_v1    <= '0;
            r_v2    <= '0;
            r_rob   <= '0;
            r_cls   <= '0;
        end else begin
            r_valid <= w_disp;
            for (int i = 0; i < WIDTH; i++) begin
                r_info[i]            <= w_disp[i] ? w_info[i] : '0;
                r_pd[i*PRB +: PRB]   <= w_disp[i] ? w_pd[i]  : '0;
                r_ps1[i*PRB +: PRB]  <= w_disp[i] ? w_ps1[i] : '0;
                r_ps2[i*PRB +: PRB]  <= w_disp[i] ? w_ps2[i] : '0;
                r_v1[i]              <= w_disp[i] & w_v1[i];
                r_v2[i]              <= w_disp[i] & w_v2[i];
                r_rob[i*RIB +: RIB]  <= w_disp[i] ? rob_tail + RIB'(i) : '0;
                r_cls[i*2 +: 2]      <= w_disp[i] ? 2'(w_cls[i]) : 2'd0;
            end
        end
    end

    assign out_valid    = r_valid;
    assign out_info     = r_info;
    assign out_pd       = r_pd;
    assign out_ps1      = r_ps1;
    assign out_ps2      = r_ps2;
    assign out_v1       = r_v1;
    assign out_v2       = r_v2;
    assign out_rob_idx  = r_rob;
    assign out_rs_class = r_cls;

`ifdef RENAME_DISPATCH_RVFI_EN
    logic [63:0]          r_order;
    logic [WIDTH*64-1:0]  r_ord_o;
    logic [WIDTH*32-1:0]  r_pcw;
    logic [WIDTH*5-1:0]   r_rs1s;
    logic [WIDTH*5-1:0]   r_rs2s;
    logic [WIDTH-1:0]     r_rfwe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_order <= '0;
            r_ord_o <= '0;
            r_pcw   <= '0;
            r_rs1s  <= '0;
            r_rs2s  <= '0;
            r_rfwe  <= '0;
        end else begin
            r_order <= r_order + 64'(w_deq);
            for (int i = 0; i < WIDTH; i++) begin
                r_ord_o[i*64 +: 64] <= w_disp[i] ? r_order + 64'(i) : '0;
                r_pcw[i*32 +: 32]   <= w_disp[i] ? iq_pc[i*32 +: 32] + 32'd4 : '0;
                r_rs1s[i*5 +: 5]    <= w_disp[i] ? w_info[i].rs1 : 5'd0;
                r_rs2s[i*5 +: 5]    <= w_disp[i] ? w_info[i].rs2 : 5'd0;
                r_rfwe[i]           <= w_disp[i] & w_need[i];
            end
        end
    end

    assign out_order    = r_ord_o;
    assign out_pc_wdata = r_pcw;
    assign out_rs1_s    = r_rs1s;
    assign out_rs2_s    = r_rs2s;
    assign out_regf_we  = r_rfwe;
`else
    // PC only feeds the monitor path.
    logic w_unused_pc;
    assign w_unused_pc = ^iq_pc;
`endif

endmodule

// File: tb/tb_rename_dispatch_nw.sv
// Directed bench for rename_dispatch_nw (WIDTH=2): resource limits,
// bypass, class limits, ROB wrap, flush and asynchronous reset.
module tb_rename_dispatch_nw;
    import rename_dispatch_nw_pkg::*;

    localparam int W   = 2;
    localparam int PRB = 6;
    localparam int RIB = 5;
    localparam int NRS = 3;
    localparam int CB  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0]       iq_valid;
    logic [W*32-1:0]    iq_inst;
    logic [W*32-1:0]    iq_pc;
    logic [CB-1:0]      iq_deq_cnt;
    logic [CB-1:0]      fl_avail;
    logic [W*PRB-1:0]   fl_preg;
    logic [CB-1:0]      fl_deq_cnt;
    logic [CB-1:0]      rob_free;
    logic [RIB-1:0]     rob_tail;
    logic [NRS*CB-1:0]  rs_free;
    logic [W*5-1:0]     rat_rs1, rat_rs2, rat_rd;
    logic [W*PRB-1:0]   rat_ps1, rat_ps2, rat_pd;
    logic [W-1:0]       rat_v1, rat_v2, rat_we;
    logic [W-1:0]       out_valid, out_v1, out_v2;
    decode_info_t [W-1:0] out_info;
    logic [W*PRB-1:0]   out_pd, out_ps1, out_ps2;
    logic [W*RIB-1:0]   out_rob_idx;
    logic [W*2-1:0]     out_rs_class;
`ifdef RENAME_DISPATCH_RVFI_EN
    logic [W*64-1:0]    out_order;
    logic [W*32-1:0]    out_pc_wdata;
    logic [W*5-1:0]     out_rs1_s, out_rs2_s;
    logic [W-1:0]       out_regf_we;
`endif

    rename_dispatch_nw dut (
        .clk(clk), .rst(rst), .flush(flush),
        .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc),
        .iq_deq_cnt(iq_deq_cnt),
        .fl_avail(fl_avail), .fl_preg(fl_preg), .fl_deq_cnt(fl_deq_cnt),
        .rob_free(rob_free), .rob_tail(rob_tail), .rs_free(rs_free),
        .rat_rs1(rat_rs1), .rat_rs2(rat_rs2),
        .rat_ps1(rat_ps1), .rat_ps2(rat_ps2),
        .rat_v1(rat_v1), .rat_v2(rat_v2),
        .rat_we(rat_we), .rat_rd(rat_rd), .rat_pd(rat_pd),
        .out_valid(out_valid), .out_info(out_info),
        .out_pd(out_pd), .out_ps1(out_ps1), .out_ps2(out_ps2),
        .out_v1(out_v1), .out_v2(out_v2),
        .out_rob_idx(out_rob_idx),
`ifdef RENAME_DISPATCH_RVFI_EN
        .out_order(out_order), .out_pc_wdata(out_pc_wdata),
        .out_rs1_s(out_rs1_s), .out_rs2_s(out_rs2_s),
        .out_regf_we(out_regf_we),
`endif
        .out_rs_class(out_rs_class)
    );

    // RAT model: x<n> maps to preg 32+n, always ready.
    always_comb begin
        for (int i = 0; i < W; i++) begin
            rat_ps1[i*PRB +: PRB] = {1'b1, rat_rs1[i*5 +: 5]};
            rat_ps2[i*PRB +: PRB] = {1'b1, rat_rs2[i*5 +: 5]};
        end
        rat_v1 = '1;
        rat_v2 = '1;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [6:0] f7,
        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic [2:0] f3);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] add(input logic [4:0] rd, rs1, rs2);
        return rtype(7'd0, rd, rs1, rs2, 3'd0);
    endfunction
    function automatic logic [31:0] mul(input logic [4:0] rd, rs1, rs2);
        return rtype(7'd1, rd, rs1, rs2, 3'd0);
    endfunction
    function automatic logic [31:0] div(input logic [4:0] rd, rs1, rs2);
        return rtype(7'd1, rd, rs1, rs2, 3'd4);
    endfunction

    localparam logic [8:0] RS_PLENTY = {3'd2, 3'd2, 3'd2};
    localparam logic [8:0] RS_MUL1   = {3'd2, 3'd1, 3'd2};
    localparam logic [8:0] RS_MUL0   = {3'd2, 3'd0, 3'd2};

    task automatic set(input logic [31:0] i0, input logic [31:0] i1,
        input logic [1:0] v, input logic [2:0] fl, input logic [2:0] rob,
        input logic [8:0] rs);
        iq_inst  = {i1, i0};
        iq_valid = v;
        fl_avail = fl;
        rob_free = rob;
        rs_free  = rs;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        fl_preg  = {6'd12, 6'd9};
        rob_tail = 5'd3;
        iq_pc    = {32'h104, 32'h100};
        set(add(3, 1, 2), add(4, 1, 2), 2'b11, 3'd2, 3'd7, RS_PLENTY);
        #1 rst = 1'b1;
        #2;
        chk("rst_deq", iq_deq_cnt, 0);
        chk("rst_fldeq", fl_deq_cnt, 0);
        chk("rst_we", rat_we, 0);
        chk("rst_rd", rat_rd, 0);
        chk("rst_valid", out_valid, 0);
        @(negedge clk) rst = 1'b0;

        // Two independent adds, lane0 reads x0.
        set(add(3, 0, 2), add(4, 1, 2), 2'b11, 3'd2, 3'd7, RS_PLENTY);
        #1;
        chk("t1_deq", iq_deq_cnt, 2);
        chk("t1_fldeq", fl_deq_cnt, 2);
        chk("t1_we", rat_we, 2'b11);
        chk("t1_rs1", rat_rs1, {5'd1, 5'd0});
        chk("t1_pd", rat_pd, {6'd12, 6'd9});
        edge1();
        chk("t1_valid", out_valid, 2'b11);
        chk("t1_ps1", out_ps1, {6'd33, 6'd0});
        chk("t1_v1", out_v1, 2'b11);
        chk("t1_ps2", out_ps2, {6'd34, 6'd34});
        chk("t1_rob", out_rob_idx, {5'd4, 5'd3});
        chk("t1_cls", out_rs_class, 0);

        // RAW bypass lane0 -> lane1.
        @(negedge clk);
        set(add(5, 1, 2), add(6, 5, 1), 2'b11, 3'd2, 3'd7, RS_PLENTY);
        edge1();
        chk("t2_ps1", out_ps1, {6'd9, 6'd33});
        chk("t2_v1", out_v1, 2'b01);
        chk("t2_ps2", out_ps2, {6'd33, 6'd34});
        chk("t2_v2", out_v2, 2'b11);
        chk("t2_pd", out_pd, {6'd12, 6'd9});
        chk("t2_rd1", out_info[1].rd, 6);

        // Free-list limited.
        @(negedge clk);
        set(add(3, 1, 2), add(4, 1, 2), 2'b11, 3'd1, 3'd7, RS_PLENTY);
        #1;
        chk("t3a_deq", iq_deq_cnt, 1);
        chk("t3a_fldeq", fl_deq_cnt, 1);
        edge1();
        chk("t3a_valid", out_valid, 2'b01);
        chk("t3a_info1", out_info[1], 0);

        // rd=x0 lane takes no free reg.
        @(negedge clk);
        set(add(0, 1, 2), add(7, 1, 2), 2'b11, 3'd1, 3'd7, RS_PLENTY);
        #1;
        chk("t3b_deq", iq_deq_cnt, 2);
        chk("t3b_fldeq", fl_deq_cnt, 1);
        chk("t3b_we", rat_we, 2'b10);
        edge1();
        chk("t3b_valid", out_valid, 2'b11);
        chk("t3b_pd", out_pd, {6'd9, 6'd0});

        // Mul RS limit.
        @(negedge clk);
        set(mul(3, 1, 2), mul(4, 1, 2), 2'b11, 3'd2, 3'd7, RS_MUL1);
        #1;
        chk("t4a_deq", iq_deq_cnt, 1);
        edge1();
        chk("t4a_valid", out_valid, 2'b01);
        chk("t4a_cls", out_rs_class, 4'b0001);

        // Blocked head stalls the whole group.
        @(negedge clk);
        set(mul(3, 1, 2), add(4, 1, 2), 2'b11, 3'd2, 3'd7, RS_MUL0);
        #1;
        chk("t4b_deq", iq_deq_cnt, 0);
        chk("t4b_fldeq", fl_deq_cnt, 0);
        edge1();
        chk("t4b_valid", out_valid, 2'b00);

        // Div class.
        @(negedge clk);
        set(div(3, 1, 2), add(4, 1, 2), 2'b11, 3'd2, 3'd7, RS_PLENTY);
        #1;
        chk("t4c_deq", iq_deq_cnt, 2);
        edge1();
        chk("t4c_cls", out_rs_class, 4'b0010);

        // ROB index wrap.
        @(negedge clk);
        rob_tail = 5'd31;
        set(add(3, 1, 2), add(4, 1, 2), 2'b11, 3'd2, 3'd7, RS_PLENTY);
        edge1();
        chk("t5_rob", out_rob_idx, {5'd0, 5'd31});

        // ROB space for one.
        @(negedge clk);
        rob_tail = 5'd3;
        set(add(3, 1, 2), add(4, 1, 2), 2'b11, 3'd2, 3'd1, RS_PLENTY);
        #1;
        chk("rob1_deq", iq_deq_cnt, 1);
        edge1();
        chk("rob1_valid", out_valid, 2'b01);

        // Only lane0 valid.
        @(negedge clk);
        set(add(3, 1, 2), add(4, 1, 2), 2'b01, 3'd2, 3'd7, RS_PLENTY);
        #1;
        chk("v01_deq", iq_deq_cnt, 1);
        chk("v01_fldeq", fl_deq_cnt, 1);
        edge1();

        // Flush.
        @(negedge clk);
        flush = 1'b1;
        set(add(3, 1, 2), add(4, 1, 2), 2'b11, 3'd2, 3'd7, RS_PLENTY);
        #1;
        chk("fl_deq", iq_deq_cnt, 0);
        chk("fl_we", rat_we, 0);
        chk("fl_fldeq", fl_deq_cnt, 0);
        edge1();
        chk("fl_valid", out_valid, 0);

        // Reset mid-cycle after a full dispatch.
        @(negedge clk);
        flush = 1'b0;
        edge1();
        chk("pre_rst_valid", out_valid, 2'b11);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_deq", iq_deq_cnt, 0);
        chk("mid_rst_pd", out_pd, 0);
        @(negedge clk) rst = 1'b0;
        edge1();
        chk("post_rst_valid", out_valid, 2'b11);
        chk("post_rst_rob", out_rob_idx, {5'd4, 5'd3});

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
